sprite_motion: RTL

Parametrised per-frame motion controller for one square sprite (ball, cursor or falling tile) on the 640x480 HDMI raster.
- Updates the sprite centre once per frame_clk edge from a per-axis direction register and a runtime speed multiplier.
- Edge behaviour is selectable: bounce, wrap or clamp.
- Keyboard direction keys steer the sprite; a pause key freezes it.
- Feeds the colour mapper with position and size, and game logic with an edge-hit pulse.

---
 rtl/sprite_motion.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sprite_motion.sv
// Per-frame motion controller for one square sprite on the 640x480 raster.
// Selectable bounce/wrap/clamp edges, keyboard steering and a pause toggle.
module sprite_motion #(
   parameter int X_MIN = 0,
   parameter int X_MAX = 639,
   parameter int Y_MIN = 0,
   parameter int Y_MAX = 479,
   parameter int X_START = 320,
   parameter int Y_START = 240,
   parameter int SIZE = 16,
   parameter int STEP = 1,
   parameter int SPEED_W = 4,
   parameter int EDGE_MODE = 0,
   parameter logic [7:0] KEY_UP = 8'h1A,
   parameter logic [7:0] KEY_DOWN = 8'h16,
   parameter logic [7:0] KEY_LEFT = 8'h04,
   parameter logic [7:0] KEY_RIGHT = 8'h07,
   parameter logic [7:0] KEY_PAUSE = 8'h2C
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic [7:0]         keycode,
   input  logic [SPEED_W-1:0] speed,
   output logic [9:0]         SpriteX,
   output logic [9:0]         SpriteY,
   output logic [9:0]         SpriteS,
   output logic [1:0]         DirX,
   output logic [1:0]         DirY,
   output logic               edge_hit,
   output logic               paused
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_PAUSED = 1'b1;

   localparam logic [1:0] DIR_POS  = 2'b01;
   localparam logic [1:0] DIR_NEG  = 2'b11;
   localparam logic [1:0] DIR_ZERO = 2'b00;

   localparam logic [1:0] MODE = 2'(EDGE_MODE);

   localparam logic signed [11:0] LO_X = 12'(X_MIN + SIZE);
   localparam logic signed [11:0] HI_X = 12'(X_MAX - SIZE);
   localparam logic signed [11:0] LO_Y = 12'(Y_MIN + SIZE);
   localparam logic signed [11:0] HI_Y = 12'(Y_MAX - SIZE);

   typedef struct packed {
      logic [9:0] pos;
      logic [1:0] dir;
      logic       hit;
   } axis_t;

   // One axis of motion: signed 12-bit sum so crossing 0 or 1023 never aliases.
   function automatic axis_t axis_step(input logic [9:0] pos, input logic [1:0] dir,
                                       input logic [11:0] mag,
                                       input logic signed [11:0] lo,
                                       input logic signed [11:0] hi);
      logic signed [11:0] p;
      logic signed [11:0] nxt;
      axis_t r;
      p = signed'({2'b00, pos});
      case (dir)
         DIR_POS: nxt = p + signed'(mag);
         DIR_NEG: nxt = p - signed'(mag);
         default: nxt = p;
      endcase
      r.pos = pos;
      r.dir = dir;
      r.hit = 1'b0;
      if (nxt > hi) begin
         r.hit = 1'b1;
         r.pos = (MODE == 2'd1) ? 10'(lo) : 10'(hi);
         r.dir = (MODE == 2'd0) ? DIR_NEG : ((MODE == 2'd1) ? dir : DIR_ZERO);
      end else if (nxt < lo) begin
         r.hit = 1'b1;
         r.pos = (MODE == 2'd1) ? 10'(hi) : 10'(lo);
         r.dir = (MODE == 2'd0) ? DIR_POS : ((MODE == 2'd1) ? dir : DIR_ZERO);
      end else begin
         r.pos = 10'(nxt);
      end
      return r;
   endfunction

   logic [9:0]         r_x, r_y;
   logic [1:0]         r_dx, r_dy;
   logic               r_hit;
   logic [0:0]         r_state;
   logic [7:0]         r_key_prev;

   logic [SPEED_W-1:0] w_spd;
   logic [11:0]        w_mag;
   logic               w_pause_rise;
   axis_t              w_ax, w_ay;
   logic [9:0]         w_nx, w_ny;
   logic [1:0]         w_ndx, w_ndy;
   logic               w_nhit;
   logic [0:0]         w_nstate;

   assign w_spd        = (speed == '0) ? SPEED_W'(1) : speed;
   assign w_mag        = 12'(STEP * int'(w_spd));
   assign w_pause_rise = (keycode == KEY_PAUSE) && (r_key_prev != KEY_PAUSE);
   assign w_ax         = axis_step(r_x, r_dx, w_mag, LO_X, HI_X);
   assign w_ay         = axis_step(r_y, r_dy, w_mag, LO_Y, HI_Y);

   // Next-state: pause edge beats keys; keys beat edge-induced direction changes.
   always_comb begin
      w_nx     = r_x;
      w_ny     = r_y;
      w_ndx    = r_dx;
      w_ndy    = r_dy;
      w_nhit   = 1'b0;
      w_nstate = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_pause_rise) begin
               w_nstate = ST_PAUSED;
            end else begin
               w_nx   = w_ax.pos;
               w_ny   = w_ay.pos;
               w_ndx  = w_ax.dir;
               w_ndy  = w_ay.dir;
               w_nhit = w_ax.hit | w_ay.hit;
               case (keycode)
                  KEY_UP:    begin w_ndy = DIR_NEG; w_ndx = DIR_ZERO; end
                  KEY_DOWN:  begin w_ndy = DIR_POS; w_ndx = DIR_ZERO; end
                  KEY_LEFT:  begin w_ndx = DIR_NEG; w_ndy = DIR_ZERO; end
                  KEY_RIGHT: begin w_ndx = DIR_POS; w_ndy = DIR_ZERO; end
                  default:   begin end
               endcase
            end
         end
         ST_PAUSED: begin
            if (w_pause_rise) begin
               w_nstate = ST_RUN;
            end else begin
               w_nstate = ST_PAUSED;
            end
         end
         default: w_nstate = ST_RUN;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         r_x        <= 10'(X_START);
         r_y        <= 10'(Y_START);
         r_dx       <= DIR_POS;
         r_dy       <= DIR_ZERO;
         r_hit      <= 1'b0;
         r_state    <= ST_RUN;
         r_key_prev <= 8'h00;
      end else begin
         r_x        <= w_nx;
         r_y        <= w_ny;
         r_dx       <= w_ndx;
         r_dy       <= w_ndy;
         r_hit      <= w_nhit;
         r_state    <= w_nstate;
         r_key_prev <= keycode;
      end
   end

   assign SpriteX  = r_x;
   assign SpriteY  = r_y;
   assign SpriteS  = 10'(SIZE);
   assign DirX     = r_dx;
   assign DirY     = r_dy;
   assign edge_hit = r_hit;
   assign paused   = (r_state == ST_PAUSED);

endmodule
